// File: rtl/portal_msg_arbiter.sv
// Round-robin, message-atomic arbiter sharing one 32-bit message-source channel
// among NREQ portal indication requesters, with one registered output beat.
module portal_msg_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_beat,
  output logic [NREQ-1:0]      req_ready,
  output logic                 msg_src_rdy,
  output logic [31:0]          msg_beat,
  input  logic                 msg_dst_rdy,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [31:0]          msg_count
);

  localparam int NEXT = 2**IDW;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  r_state, w_state_nxt;
  logic [IDW-1:0]          r_grant_id, r_last_grant, w_pick;
  logic                    w_any;
  logic                    r_first;
  logic [15:0]             r_beats_left, w_beats_left_nxt, w_len;
  logic                    r_src_rdy;
  logic [31:0]             r_beat, r_msg_count, w_beat;
  logic [NEXT-1:0]         w_valid_ext;
  logic [NEXT-1:0][31:0]   w_beats_ext;
  logic                    w_free, w_accept, w_last_beat;

  // Widen request vectors to the full grant_id range so they index cleanly.
  always_comb begin
    w_valid_ext              = NEXT'(req_valid);
    w_beats_ext              = '0;
    w_beats_ext[NREQ-1:0]    = req_beat;
  end

  // Scan downwards so the requester closest after last_grant wins.
  always_comb begin
    int idx;
    idx    = 0;
    w_pick = r_last_grant;
    w_any  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(r_last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (w_valid_ext[IDW'(idx)]) begin
        w_pick = IDW'(idx);
        w_any  = 1'b1;
      end
    end
  end

  // Output register is free when empty or being drained this cycle.
  assign w_free   = !r_src_rdy || msg_dst_rdy;
  assign w_accept = (r_state == SEND) && w_free && w_valid_ext[r_grant_id];
  assign w_beat   = w_beats_ext[r_grant_id];
  assign w_len    = w_beat[15:0];

  always_comb begin
    if (r_first) w_beats_left_nxt = (w_len == 16'd0) ? 16'd0 : w_len - 16'd1;
    else         w_beats_left_nxt = r_beats_left - 16'd1;
  end

  assign w_last_beat = w_accept && (w_beats_left_nxt == 16'd0);

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = (r_state == SEND) && w_free && (r_grant_id == IDW'(i));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_any)       w_state_nxt = SEND;
      SEND: if (w_last_beat) w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= IDW'(NREQ-1);
      r_first      <= 1'b0;
      r_beats_left <= '0;
      r_msg_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) begin
        r_grant_id <= w_pick;
        r_first    <= 1'b1;
      end
      if (w_accept) begin
        r_beats_left <= w_beats_left_nxt;
        r_first      <= 1'b0;
      end
      if (w_last_beat) begin
        r_last_grant <= r_grant_id;
        r_msg_count  <= r_msg_count + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_src_rdy <= 1'b0;
      r_beat    <= '0;
    end else if (w_accept) begin
      r_src_rdy <= 1'b1;
      r_beat    <= w_beat;
    end else if (msg_dst_rdy) begin
      r_src_rdy <= 1'b0;
    end
  end

  assign msg_src_rdy = r_src_rdy;
  assign msg_beat    = r_beat;
  assign busy        = (r_state == SEND);
  assign grant_id    = r_grant_id;
  assign msg_count   = r_msg_count;

endmodule

// File: tb/tb_portal_msg_arbiter.sv
// Bench for portal_msg_arbiter: directed scenarios plus randomized traffic
// checked against a message-level round-robin model.
module tb_portal_msg_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 4;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_beat;
  logic [NREQ-1:0]      req_ready;
  logic                 msg_src_rdy;
  logic [31:0]          msg_beat;
  logic                 msg_dst_rdy;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic [31:0]          msg_count;

  portal_msg_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_beat(req_beat),
    .req_ready(req_ready), .msg_src_rdy(msg_src_rdy), .msg_beat(msg_beat),
    .msg_dst_rdy(msg_dst_rdy), .busy(busy), .grant_id(grant_id),
    .msg_count(msg_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] rq[NREQ][$];
  int          pos[NREQ];
  int          mlen[NREQ];
  bit          hold[NREQ];
  bit          drop_en;
  int          dst_mode;
  int          pat_k;
  int          cyc = 0;
  logic [31:0] obs_q[$];
  int          obs_c[$];
  bit          prev_stall;
  logic [31:0] prev_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive requesters from their queues, sample, retire accepted beats.
  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge CLK);
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0 && !hold[i] &&
          !(drop_en && pos[i] != 0 && $urandom_range(0, 3) == 0)) begin
        req_valid[i]          = 1'b1;
        req_beat[32*i +: 32]  = rq[i][0];
      end else begin
        req_valid[i]          = 1'b0;
        req_beat[32*i +: 32]  = $urandom;
      end
    end
    case (dst_mode)
      0: msg_dst_rdy = ($urandom_range(0, 3) != 0);
      1: msg_dst_rdy = 1'b1;
      2: begin msg_dst_rdy = (pat_k % 3 == 0); pat_k++; end
      default: msg_dst_rdy = 1'b0;
    endcase
    #1;
    acc = req_valid & req_ready;
    if (prev_stall) chk("stall_hold", msg_beat, prev_beat);
    if (msg_src_rdy && msg_dst_rdy) begin
      obs_q.push_back(msg_beat);
      obs_c.push_back(cyc);
    end
    prev_stall = msg_src_rdy && !msg_dst_rdy;
    prev_beat  = msg_beat;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        if (pos[i] == 0) mlen[i] = (rq[i][0][15:0] == 16'd0) ? 1 : int'(rq[i][0][15:0]);
        pos[i]++;
        void'(rq[i].pop_front());
        if (pos[i] == mlen[i]) pos[i] = 0;
      end
    end
    cyc++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      pos[i]  = 0;
      mlen[i] = 0;
      hold[i] = 1'b0;
    end
    obs_q.delete();
    obs_c.delete();
    prev_stall = 1'b0;
    drop_en    = 1'b0;
    req_valid  = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    clear_model();
    msg_dst_rdy = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] tq[NREQ][$];
    int          mq[NREQ][$];
    int          c0, nmsg, last, remaining, j, n;
    logic [31:0] hdr;
    bit          found;

    RST_N = 1'b0; req_valid = '0; req_beat = '0; msg_dst_rdy = 1'b0;
    dst_mode = 1; pat_k = 0;
    clear_model();
    #3;
    chk("rst_src_rdy", 32'(msg_src_rdy), 32'd0);
    chk("rst_beat", msg_beat, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_count", msg_count, 32'd0);
    do_reset();

    // Single 3-beat message from requester 2
    rq[2] = '{32'h00AB0003, 32'hD1D1D1D1, 32'hD2D2D2D2};
    dst_mode = 1;
    c0 = cyc;
    tick(); chk("t1_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant_id), 32'd2);
    chk("t1_ready", 32'(req_ready), 32'h4);
    repeat (3) tick();
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_count", msg_count, 32'd1);
    chk("t1_nbeats", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      chk("t1_b0", obs_q[0], 32'h00AB0003);
      chk("t1_b1", obs_q[1], 32'hD1D1D1D1);
      chk("t1_b2", obs_q[2], 32'hD2D2D2D2);
      chk("t1_lat0", 32'(obs_c[0] - c0), 32'd2);
      chk("t1_lat1", 32'(obs_c[1] - c0), 32'd3);
      chk("t1_lat2", 32'(obs_c[2] - c0), 32'd4);
    end

    // Round-robin with 1-beat messages, all requesters always valid
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int m = 0; m < 2; m++) rq[i].push_back({16'(i), 16'h0001});
    repeat (20) tick();
    chk("rr_nbeats", 32'(obs_q.size()), 32'd8);
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      chk("rr_order", obs_q[k], {16'(k % NREQ), 16'h0001});
      if (k > 0) chk("rr_spacing", 32'(obs_c[k] - obs_c[k-1]), 32'd2);
    end
    chk("rr_count", msg_count, 32'd8);

    // Backpressure with consumer ready pattern 1,0,0 repeating
    obs_q.delete(); obs_c.delete();
    rq[1] = '{32'h55550004, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    dst_mode = 2; pat_k = 0;
    repeat (25) tick();
    chk("bp_nbeats", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) begin
      chk("bp_b0", obs_q[0], 32'h55550004);
      chk("bp_b1", obs_q[1], 32'hA1A1A1A1);
      chk("bp_b2", obs_q[2], 32'hA2A2A2A2);
      chk("bp_b3", obs_q[3], 32'hA3A3A3A3);
    end
    chk("bp_count", msg_count, 32'd9);

    // Zero-length header is a single-beat message
    dst_mode = 1;
    repeat (2) tick();
    obs_q.delete(); obs_c.delete();
    rq[0] = '{32'h12340000};
    tick();
    tick(); chk("z_busy_send", 32'(busy), 32'd1);
    tick();
    chk("z_busy_idle", 32'(busy), 32'd0);
    chk("z_count", msg_count, 32'd10);
    repeat (2) tick();
    chk("z_nbeats", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) chk("z_b0", obs_q[0], 32'h12340000);

    // Granted requester stalls mid-message, then asynchronous reset
    rq[3] = '{32'h00000005, 32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3, 32'hE4E4E4E4};
    rq[0] = '{32'hABCD0001};
    for (int k = 0; k < 20 && pos[3] != 2; k++) tick();
    chk("st_pos", 32'(pos[3]), 32'd2);
    hold[3] = 1'b1;
    repeat (3) tick();
    chk("st_busy", 32'(busy), 32'd1);
    chk("st_grant", 32'(grant_id), 32'd3);
    chk("st_others", 32'(req_ready & ~NREQ'(8)), 32'd0);
    hold[3] = 1'b0;
    dst_mode = 3;
    tick();
    tick();
    chk("st_src_rdy", 32'(msg_src_rdy), 32'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("ar_src_rdy", 32'(msg_src_rdy), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_count", msg_count, 32'd0);
    chk("ar_ready", 32'(req_ready), 32'd0);
    clear_model();
    @(negedge CLK); RST_N = 1'b1;
    dst_mode = 1;
    rq[0] = '{32'h00000001};
    rq[1] = '{32'h00010001};
    tick(); tick();
    chk("ar_regrant", 32'(grant_id), 32'd0);
    repeat (6) tick();
    chk("ar_count2", msg_count, 32'd2);

    // msg_count wrap
    @(negedge CLK);
    force dut.r_msg_count = 32'hFFFFFFFF;
    #1 release dut.r_msg_count;
    #1 chk("wrap_pre", msg_count, 32'hFFFFFFFF);
    rq[2] = '{32'h00000001};
    repeat (4) tick();
    chk("wrap_post", msg_count, 32'd0);

    // Randomized traffic against a message-level round-robin model
    do_reset();
    nmsg = 0;
    for (int i = 0; i < NREQ; i++) begin
      tq[i].delete(); mq[i].delete();
      n = $urandom_range(2, 4);
      for (int m = 0; m < n; m++) begin
        int len, nb;
        len = $urandom_range(0, 5);
        hdr = {16'($urandom), 16'(len)};
        nb  = (len == 0) ? 1 : len;
        mq[i].push_back(nb);
        rq[i].push_back(hdr); tq[i].push_back(hdr);
        for (int b = 1; b < nb; b++) begin
          logic [31:0] d;
          d = $urandom;
          rq[i].push_back(d); tq[i].push_back(d);
        end
        nmsg++;
      end
    end
    exp_q.delete();
    last = NREQ - 1;
    remaining = nmsg;
    while (remaining > 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ && !found; k++) begin
        j = (last + k) % NREQ;
        if (mq[j].size() > 0) begin
          n = mq[j].pop_front();
          for (int b = 0; b < n; b++) exp_q.push_back(tq[j].pop_front());
          last = j;
          remaining--;
          found = 1'b1;
        end
      end
    end
    drop_en = 1'b1;
    dst_mode = 0;
    for (int k = 0; k < 4000 && obs_q.size() < exp_q.size(); k++) tick();
    chk("rnd_nbeats", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk("rnd_beat", obs_q[k], exp_q[k]);
    dst_mode = 1;
    repeat (3) tick();
    chk("rnd_count", msg_count, 32'(nmsg));
    chk("rnd_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
